operand_stack: RTL

OPERAND_STACK -- requirements
Module: operand_stack

---
 rtl/stack_pkg.sv | 20 ++
 rtl/stack_regfile.sv | 29 ++
 rtl/operand_stack.sv | 136 +++++++++++++
 3 files changed

// File: rtl/stack_pkg.sv
// stack_pkg: operation and FSM state encodings shared by the operand stack and its decode logic.
package stack_pkg;

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_PUSH = 3'b001,
        OP_POP  = 3'b010,
        OP_POP2 = 3'b011,
        OP_REPL = 3'b100,
        OP_BIN  = 3'b101,
        OP_DUP  = 3'b110,
        OP_SWAP = 3'b111
    } op_e;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_ERROR = 1'b1
    } state_e;

endpackage

// File: rtl/stack_regfile.sv
// stack_regfile: DEPTH x REG_BITS storage, two write ports and two async read ports, no reset.
module stack_regfile #(
    parameter int REG_BITS = 32,
    parameter int DEPTH    = 16
) (
    input  logic                       clk,
    input  logic                       we_a,
    input  logic [$clog2(DEPTH)-1:0]   wa_a,
    input  logic [REG_BITS-1:0]        wd_a,
    input  logic                       we_b,
    input  logic [$clog2(DEPTH)-1:0]   wa_b,
    input  logic [REG_BITS-1:0]        wd_b,
    input  logic [$clog2(DEPTH)-1:0]   ra_a,
    output logic [REG_BITS-1:0]        rd_a,
    input  logic [$clog2(DEPTH)-1:0]   ra_b,
    output logic [REG_BITS-1:0]        rd_b
);

    logic [REG_BITS-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we_a) mem[wa_a] <= wd_a;
        if (we_b) mem[wa_b] <= wd_b;
    end

    assign rd_a = mem[ra_a];
    assign rd_b = mem[ra_b];

endmodule

// File: rtl/operand_stack.sv
// operand_stack: hardware operand stack with push/pop/binary-op/dup/swap and sticky
// overflow/underflow errors that stall requests until clear_err.
module operand_stack
    import stack_pkg::*;
#(
    parameter int REG_BITS = 32,
    parameter int DEPTH    = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [2:0]                 req_op,
    input  logic [REG_BITS-1:0]        req_data,
    output logic [REG_BITS-1:0]        top,
    output logic [REG_BITS-1:0]        next,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow,
    output logic                       underflow,
    input  logic                       clear_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [CW-1:0]       count_q, count_d;
    state_e              state_q, state_d;
    logic                ovf_q, ovf_d, unf_q, unf_d;
    logic [AW-1:0]       push_idx, top_idx, next_idx, wa_a, wa_b;
    logic [REG_BITS-1:0] rd_top, rd_next, wd_a, wd_b;
    logic                we_a, we_b, fire, under, over;
    op_e                 op;

    always_comb begin
        op        = op_e'(req_op);
        push_idx  = count_q[AW-1:0];
        top_idx   = push_idx - AW'(1);
        next_idx  = push_idx - AW'(2);
        req_ready = state_q == ST_RUN;
        fire      = req_valid && req_ready;
        under     = ((op inside {OP_POP, OP_REPL, OP_DUP}) && count_q < CW'(1)) ||
                    ((op inside {OP_POP2, OP_BIN, OP_SWAP}) && count_q < CW'(2));
        over      = (op inside {OP_PUSH, OP_DUP}) && count_q == CW'(DEPTH);
        count_d   = count_q;
        state_d   = state_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        we_a      = 1'b0;
        we_b      = 1'b0;
        wa_a      = push_idx;
        wd_a      = req_data;
        wa_b      = next_idx;
        wd_b      = rd_top;
        if (state_q == ST_ERROR) begin
            if (clear_err) begin
                state_d = ST_RUN;
                ovf_d   = 1'b0;
                unf_d   = 1'b0;
            end
        end else if (fire && (under || over)) begin
            state_d = ST_ERROR;
            ovf_d   = ovf_q || over;
            unf_d   = unf_q || under;
        end else if (fire) begin
            case (op)
                OP_PUSH: begin
                    we_a    = 1'b1;
                    count_d = count_q + CW'(1);
                end
                OP_POP:  count_d = count_q - CW'(1);
                OP_POP2: count_d = count_q - CW'(2);
                OP_REPL: begin
                    we_a = 1'b1;
                    wa_a = top_idx;
                end
                OP_BIN: begin
                    we_a    = 1'b1;
                    wa_a    = next_idx;
                    count_d = count_q - CW'(1);
                end
                OP_DUP: begin
                    we_a    = 1'b1;
                    wd_a    = rd_top;
                    count_d = count_q + CW'(1);
                end
                OP_SWAP: begin
                    we_a = 1'b1;
                    wa_a = top_idx;
                    wd_a = rd_next;
                    we_b = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            state_q <= ST_RUN;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            state_q <= state_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Writes are gated by rst_n so an edge during reset cannot touch the unreset storage.
    stack_regfile #(.REG_BITS(REG_BITS), .DEPTH(DEPTH)) u_regfile (
        .clk  (clk),
        .we_a (we_a && rst_n),
        .wa_a (wa_a),
        .wd_a (wd_a),
        .we_b (we_b && rst_n),
        .wa_b (wa_b),
        .wd_b (wd_b),
        .ra_a (top_idx),
        .rd_a (rd_top),
        .ra_b (next_idx),
        .rd_b (rd_next)
    );

    assign top       = count_q == '0 ? '0 : rd_top;
    assign next      = count_q < CW'(2) ? '0 : rd_next;
    assign count     = count_q;
    assign full      = count_q == CW'(DEPTH);
    assign empty     = count_q == '0;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule
